// File: rtl/prga.sv
// RC4 keystream decryptor (PRGA): reads a length-prefixed ciphertext,
// evolves the pre-permuted S array and writes the plaintext.
module prga (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    output logic [7:0] s_wrdata,
    input  logic [7:0] s_rddata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    typedef enum logic [3:0] {
        IDLE, LEN_RD, LEN_WAIT, LEN_WR,
        SI_RD, SI_WAIT, SJ_RD, SJ_WAIT,
        WR_I, WR_J, PAD_RD, PAD_WAIT, PT_WR
    } state_t;

    state_t     state, state_nx;
    logic [7:0] i, j, len, si, sj;
    logic [8:0] k;
    logic [7:0] i_inc;
    logic       s_we, pt_we;

    logic [7:0] s_addr_q, s_wrdata_q, ct_addr_q, pt_addr_q, pt_wrdata_q;

    assign i_inc = i + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            i           <= 8'd0;
            j           <= 8'd0;
            k           <= 9'd0;
            len         <= 8'd0;
            si          <= 8'd0;
            sj          <= 8'd0;
            s_addr_q    <= 8'd0;
            s_wrdata_q  <= 8'd0;
            ct_addr_q   <= 8'd0;
            pt_addr_q   <= 8'd0;
            pt_wrdata_q <= 8'd0;
        end else begin
            state       <= state_nx;
            s_addr_q    <= s_addr;
            s_wrdata_q  <= s_wrdata;
            ct_addr_q   <= ct_addr;
            pt_addr_q   <= pt_addr;
            pt_wrdata_q <= pt_wrdata;
            case (state)
                IDLE: begin
                    if (en) begin
                        i <= 8'd0;
                        j <= 8'd0;
                        k <= 9'd0;
                    end
                end
                LEN_WR: begin
                    len <= ct_rddata;
                    if (ct_rddata != 8'd0)
                        k <= 9'd1;
                end
                SI_RD: i <= i_inc;
                SI_WAIT: begin
                    si <= s_rddata;
                    j  <= j + s_rddata;
                end
                SJ_WAIT: sj <= s_rddata;
                PT_WR: begin
                    if (k != {1'b0, len})
                        k <= k + 9'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs not driven by the current state replay their held value.
    always_comb begin
        state_nx  = state;
        rdy       = 1'b0;
        s_we      = 1'b0;
        pt_we     = 1'b0;
        s_addr    = s_addr_q;
        s_wrdata  = s_wrdata_q;
        ct_addr   = ct_addr_q;
        pt_addr   = pt_addr_q;
        pt_wrdata = pt_wrdata_q;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (en)
                    state_nx = LEN_RD;
            end
            LEN_RD: begin
                ct_addr  = 8'd0;
                state_nx = LEN_WAIT;
            end
            LEN_WAIT: state_nx = LEN_WR;
            LEN_WR: begin
                pt_addr   = 8'd0;
                pt_wrdata = ct_rddata;
                pt_we     = 1'b1;
                state_nx  = (ct_rddata == 8'd0) ? IDLE : SI_RD;
            end
            SI_RD: begin
                s_addr   = i_inc;
                state_nx = SI_WAIT;
            end
            SI_WAIT: state_nx = SJ_RD;
            SJ_RD: begin
                s_addr   = j;
                state_nx = SJ_WAIT;
            end
            SJ_WAIT: state_nx = WR_I;
            WR_I: begin
                s_addr   = i;
                s_wrdata = sj;
                s_we     = 1'b1;
                state_nx = WR_J;
            end
            WR_J: begin
                s_addr   = j;
                s_wrdata = si;
                s_we     = 1'b1;
                state_nx = PAD_RD;
            end
            PAD_RD: begin
                s_addr   = si + sj;
                ct_addr  = k[7:0];
                state_nx = PAD_WAIT;
            end
            PAD_WAIT: state_nx = PT_WR;
            PT_WR: begin
                pt_addr   = k[7:0];
                pt_wrdata = s_rddata ^ ct_rddata;
                pt_we     = 1'b1;
                state_nx  = (k == {1'b0, len}) ? IDLE : SI_RD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A reset cycle must not let the aborted state commit a write.
    assign s_wren  = s_we & ~reset;
    assign pt_wren = pt_we & ~reset;

endmodule
